// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, encodings and helpers for the MIPS pipeline
// registers.
//   REG_W / DATA_W / SHAMT_W / ALUCTL_W / MEMTOREG_W / CNT_W : field widths
//   regdst_e     : destination-register select encodings (rt / rd / $31)
//   memtoreg_e   : write-back source encodings
//   id_ex_t      : everything the ID/EX register carries into EX
//   resolve_dst  : maps RegDst + rt/rd to the architectural destination
//   sat_inc      : saturating increment for the event counters
package pipeline_pkg;

  localparam int REG_W      = 5;
  localparam int DATA_W     = 32;
  localparam int SHAMT_W    = 5;
  localparam int ALUCTL_W   = 5;
  localparam int REGDST_W   = 2;
  localparam int MEMTOREG_W = 2;
  localparam int CNT_W      = 16;

  localparam logic [REG_W-1:0] REG_RA = 5'd31;

  typedef enum logic [REGDST_W-1:0] {
    REGDST_RT = 2'd0,
    REGDST_RD = 2'd1,
    REGDST_RA = 2'd2
  } regdst_e;

  typedef enum logic [MEMTOREG_W-1:0] {
    MEMTOREG_ALU = 2'd0,
    MEMTOREG_MEM = 2'd1,
    MEMTOREG_PC4 = 2'd2
  } memtoreg_e;

  // An all-zero value of this struct is a bubble.
  typedef struct packed {
    logic                  valid;
    logic [REG_W-1:0]      rs;
    logic [REG_W-1:0]      rt;
    logic [REG_W-1:0]      rd;
    logic                  uses_rs;
    logic                  uses_rt;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [SHAMT_W-1:0]    shamt;
    logic [ALUCTL_W-1:0]   alu_ctl;
    logic                  alu_src1;
    logic                  alu_src2;
    logic [REGDST_W-1:0]   reg_dst;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [MEMTOREG_W-1:0] mem_to_reg;
    logic [DATA_W-1:0]     pc4;
    logic [REG_W-1:0]      dst;
  } id_ex_t;

  function automatic logic [REG_W-1:0] resolve_dst(
    input logic [REGDST_W-1:0] reg_dst,
    input logic [REG_W-1:0]    rt,
    input logic [REG_W-1:0]    rd
  );
    if (reg_dst == REGDST_RT)      return rt;
    else if (reg_dst == REGDST_RD) return rd;
    else                           return REG_RA;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard detector.
//   ex_valid, ex_mem_read, ex_dst : the instruction currently in EX
//   id_rs, id_rt, id_uses_rs, id_uses_rt : source operands of the ID instruction
//   lu : ID reads the register a load in EX is about to produce
// A load to $0 never creates a dependency, and an operand field that the
// instruction does not actually read cannot create one either.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic             lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_dst);
  assign rt_hit = id_uses_rt && (id_rt == ex_dst);
  assign lu     = ex_valid && ex_mem_read && (ex_dst != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall and branch flush.
//   clk, reset_n          : clock, asynchronous active-low reset
//   ID_*                  : decoded operands and control of the ID instruction
//   Flush                 : taken branch/jump in EX, squash the ID instruction
//   Stall                 : hold PC and IF/ID this cycle (combinational)
//   EX_*                  : registered copies of ID_* for EX
//   EX_dst, EX_valid      : resolved destination, real-instruction flag
//   StallCount/FlushCount : saturating event counters
//
// Flow control: Stall acts as a not-ready towards IF/ID. While Stall is high
// the ID instruction is not consumed; a bubble enters EX instead and the same
// instruction is presented again next cycle. Flush takes priority and turns
// the ID instruction into a bubble without asserting Stall.
module id_ex_stage
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_W-1:0]      ID_rs,
  input  logic [REG_W-1:0]      ID_rt,
  input  logic [REG_W-1:0]      ID_rd,
  input  logic                  ID_uses_rs,
  input  logic                  ID_uses_rt,
  input  logic [DATA_W-1:0]     ID_rs_data,
  input  logic [DATA_W-1:0]     ID_rt_data,
  input  logic [DATA_W-1:0]     ID_imm,
  input  logic [SHAMT_W-1:0]    ID_shamt,
  input  logic [ALUCTL_W-1:0]   ID_ALUCtl,
  input  logic                  ID_ALUSrc1,
  input  logic                  ID_ALUSrc2,
  input  logic [REGDST_W-1:0]   ID_RegDst,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_MemWrite,
  input  logic [MEMTOREG_W-1:0] ID_MemtoReg,
  input  logic [DATA_W-1:0]     ID_PC4,
  input  logic                  Flush,
  output logic                  Stall,
  output logic [REG_W-1:0]      EX_rs,
  output logic [REG_W-1:0]      EX_rt,
  output logic [REG_W-1:0]      EX_rd,
  output logic                  EX_uses_rs,
  output logic                  EX_uses_rt,
  output logic [DATA_W-1:0]     EX_rs_data,
  output logic [DATA_W-1:0]     EX_rt_data,
  output logic [DATA_W-1:0]     EX_imm,
  output logic [SHAMT_W-1:0]    EX_shamt,
  output logic [ALUCTL_W-1:0]   EX_ALUCtl,
  output logic                  EX_ALUSrc1,
  output logic                  EX_ALUSrc2,
  output logic [REGDST_W-1:0]   EX_RegDst,
  output logic                  EX_RegWrite,
  output logic                  EX_MemRead,
  output logic                  EX_MemWrite,
  output logic [MEMTOREG_W-1:0] EX_MemtoReg,
  output logic [DATA_W-1:0]     EX_PC4,
  output logic [REG_W-1:0]      EX_dst,
  output logic                  EX_valid,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount
);

  id_ex_t           cap;
  id_ex_t           ex_q;
  logic             lu;
  logic [REG_W-1:0] id_dst;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_dst      (ex_q.dst),
    .id_rs       (ID_rs),
    .id_rt       (ID_rt),
    .id_uses_rs  (ID_uses_rs),
    .id_uses_rt  (ID_uses_rt),
    .lu          (lu)
  );

  // A flush squashes whatever ID holds, so it is never a reason to stall.
  assign Stall  = lu && !Flush;

  assign id_dst = resolve_dst(ID_RegDst, ID_rt, ID_rd);

  always_comb begin
    cap            = '0;
    cap.valid      = 1'b1;
    cap.rs         = ID_rs;
    cap.rt         = ID_rt;
    cap.rd         = ID_rd;
    cap.uses_rs    = ID_uses_rs;
    cap.uses_rt    = ID_uses_rt;
    cap.rs_data    = ID_rs_data;
    cap.rt_data    = ID_rt_data;
    cap.imm        = ID_imm;
    cap.shamt      = ID_shamt;
    cap.alu_ctl    = ID_ALUCtl;
    cap.alu_src1   = ID_ALUSrc1;
    cap.alu_src2   = ID_ALUSrc2;
    cap.reg_dst    = ID_RegDst;
    // Writes to $0 are dropped here so that forwarding downstream never has
    // to check for $0 itself.
    cap.reg_write  = ID_RegWrite && (id_dst != '0);
    cap.mem_read   = ID_MemRead;
    cap.mem_write  = ID_MemWrite;
    cap.mem_to_reg = ID_MemtoReg;
    cap.pc4        = ID_PC4;
    cap.dst        = id_dst;
  end

  // Both flush and load-use insert an all-zero bubble; the bubble clears
  // mem_read, which is what limits a stall to a single cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q <= '0;
    end else if (Flush || lu) begin
      ex_q <= '0;
    end else begin
      ex_q <= cap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (Flush) begin
      flush_cnt_q <= sat_inc(flush_cnt_q);
    end else if (lu) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign EX_rs       = ex_q.rs;
  assign EX_rt       = ex_q.rt;
  assign EX_rd       = ex_q.rd;
  assign EX_uses_rs  = ex_q.uses_rs;
  assign EX_uses_rt  = ex_q.uses_rt;
  assign EX_rs_data  = ex_q.rs_data;
  assign EX_rt_data  = ex_q.rt_data;
  assign EX_imm      = ex_q.imm;
  assign EX_shamt    = ex_q.shamt;
  assign EX_ALUCtl   = ex_q.alu_ctl;
  assign EX_ALUSrc1  = ex_q.alu_src1;
  assign EX_ALUSrc2  = ex_q.alu_src2;
  assign EX_RegDst   = ex_q.reg_dst;
  assign EX_RegWrite = ex_q.reg_write;
  assign EX_MemRead  = ex_q.mem_read;
  assign EX_MemWrite = ex_q.mem_write;
  assign EX_MemtoReg = ex_q.mem_to_reg;
  assign EX_PC4      = ex_q.pc4;
  assign EX_dst      = ex_q.dst;
  assign EX_valid    = ex_q.valid;
  assign StallCount  = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage with hand-computed
// expectations for reset, load-use stall, false dependencies, $0 squash,
// flush priority, back-to-back loads and counter saturation.
module tb_id_ex_stage;

  logic        clk;
  logic        reset_n;
  logic [4:0]  ID_rs, ID_rt, ID_rd;
  logic        ID_uses_rs, ID_uses_rt;
  logic [31:0] ID_rs_data, ID_rt_data, ID_imm;
  logic [4:0]  ID_shamt, ID_ALUCtl;
  logic        ID_ALUSrc1, ID_ALUSrc2;
  logic [1:0]  ID_RegDst;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite;
  logic [1:0]  ID_MemtoReg;
  logic [31:0] ID_PC4;
  logic        Flush;
  logic        Stall;
  logic [4:0]  EX_rs, EX_rt, EX_rd;
  logic        EX_uses_rs, EX_uses_rt;
  logic [31:0] EX_rs_data, EX_rt_data, EX_imm;
  logic [4:0]  EX_shamt, EX_ALUCtl;
  logic        EX_ALUSrc1, EX_ALUSrc2;
  logic [1:0]  EX_RegDst;
  logic        EX_RegWrite, EX_MemRead, EX_MemWrite;
  logic [1:0]  EX_MemtoReg;
  logic [31:0] EX_PC4;
  logic [4:0]  EX_dst;
  logic        EX_valid;
  logic [15:0] StallCount, FlushCount;

  int vectors;
  int miscompares;
  int exp_stall;
  int exp_flush;

  id_ex_stage dut (
    .clk(clk), .reset_n(reset_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data), .ID_imm(ID_imm),
    .ID_shamt(ID_shamt), .ID_ALUCtl(ID_ALUCtl),
    .ID_ALUSrc1(ID_ALUSrc1), .ID_ALUSrc2(ID_ALUSrc2),
    .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_PC4(ID_PC4),
    .Flush(Flush), .Stall(Stall),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
    .EX_uses_rs(EX_uses_rs), .EX_uses_rt(EX_uses_rt),
    .EX_rs_data(EX_rs_data), .EX_rt_data(EX_rt_data), .EX_imm(EX_imm),
    .EX_shamt(EX_shamt), .EX_ALUCtl(EX_ALUCtl),
    .EX_ALUSrc1(EX_ALUSrc1), .EX_ALUSrc2(EX_ALUSrc2),
    .EX_RegDst(EX_RegDst), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemtoReg(EX_MemtoReg), .EX_PC4(EX_PC4),
    .EX_dst(EX_dst), .EX_valid(EX_valid),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Data fields are derived from the register numbers so expectations can be
  // written by hand: rs_data = A5A50000+rs, rt_data = 5A5A0000+rt,
  // imm = 100+rd, shamt = rd, PC4 = 400+rd.
  task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic urs,
                             input logic urt, input logic [1:0] regdst,
                             input logic rw, input logic mr, input logic mw);
    ID_rs       = rs;
    ID_rt       = rt;
    ID_rd       = rd;
    ID_uses_rs  = urs;
    ID_uses_rt  = urt;
    ID_rs_data  = 32'hA5A5_0000 + {27'd0, rs};
    ID_rt_data  = 32'h5A5A_0000 + {27'd0, rt};
    ID_imm      = 32'h0000_0100 + {27'd0, rd};
    ID_shamt    = rd;
    ID_ALUCtl   = 5'h03;
    ID_ALUSrc1  = 1'b0;
    ID_ALUSrc2  = mr | mw;
    ID_RegDst   = regdst;
    ID_RegWrite = rw;
    ID_MemRead  = mr;
    ID_MemWrite = mw;
    ID_MemtoReg = mr ? 2'd1 : 2'd0;
    ID_PC4      = 32'h0000_0400 + {27'd0, rd};
  endtask

  task automatic drive_nop();
    drive_instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // lw $dst, 0($base)
  task automatic drive_lw(input logic [4:0] dst, input logic [4:0] base);
    drive_instr(base, dst, 5'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(); step();
    vectors++; if (EX_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", EX_valid); end
    vectors++; if ({EX_rs, EX_rt, EX_dst, EX_rs_data, EX_PC4} !== '0) begin miscompares++; $display("FAIL reset_fields got=%h exp=0", {EX_rs, EX_rt, EX_dst, EX_rs_data, EX_PC4}); end
    vectors++; if ({StallCount, FlushCount} !== 32'd0) begin miscompares++; $display("FAIL reset_counters got=%h exp=0", {StallCount, FlushCount}); end
    vectors++; if (Stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got=%b exp=0", Stall); end
    // Release after an edge; the first capture is the next edge.
    drive_instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    vectors++; if (EX_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_early_capture got=%b exp=0", EX_valid); end
    step();
    vectors++; if (EX_valid !== 1'b1 || EX_dst !== 5'd3 || EX_rs_data !== 32'hA5A5_0001) begin miscompares++; $display("FAIL reset_first_capture got=%b/%0d/%h exp=1/3/a5a50001", EX_valid, EX_dst, EX_rs_data); end
    // Reset in the middle of a stall.
    drive_lw(5'd8, 5'd9);
    step();
    drive_instr(5'd8, 5'd11, 5'd10, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++; if (Stall !== 1'b1) begin miscompares++; $display("FAIL reset_prestall got=%b exp=1", Stall); end
    #1 reset_n = 1'b0;
    #1;
    vectors++; if (Stall !== 1'b0 || EX_valid !== 1'b0 || EX_MemRead !== 1'b0) begin miscompares++; $display("FAIL reset_async got=%b/%b/%b exp=0/0/0", Stall, EX_valid, EX_MemRead); end
    step();
    reset_n = 1'b1;
    vectors++; if (StallCount !== 16'd0) begin miscompares++; $display("FAIL reset_midstall_count got=%0d exp=0", StallCount); end
    drive_nop();
    step();
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_load_use();
    drive_lw(5'd8, 5'd9);
    step();
    vectors++; if (EX_dst !== 5'd8 || EX_MemRead !== 1'b1 || EX_valid !== 1'b1) begin miscompares++; $display("FAIL lu_load_in_ex got=%0d/%b/%b exp=8/1/1", EX_dst, EX_MemRead, EX_valid); end
    // add $10, $8, $11
    drive_instr(5'd8, 5'd11, 5'd10, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++; if (Stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall got=%b exp=1", Stall); end
    step();
    exp_stall++;
    vectors++; if (EX_valid !== 1'b0 || EX_dst !== 5'd0 || EX_rs !== 5'd0 || EX_RegWrite !== 1'b0) begin miscompares++; $display("FAIL lu_bubble got=%b/%0d/%0d/%b exp=0/0/0/0", EX_valid, EX_dst, EX_rs, EX_RegWrite); end
    vectors++; if (StallCount !== 16'(exp_stall)) begin miscompares++; $display("FAIL lu_count got=%0d exp=%0d", StallCount, exp_stall); end
    vectors++; if (Stall !== 1'b0) begin miscompares++; $display("FAIL lu_one_cycle got=%b exp=0", Stall); end
    step();
    vectors++; if (EX_valid !== 1'b1 || EX_rs !== 5'd8 || EX_rt !== 5'd11 || EX_dst !== 5'd10 || EX_RegWrite !== 1'b1) begin miscompares++; $display("FAIL lu_replay got=%b/%0d/%0d/%0d/%b exp=1/8/11/10/1", EX_valid, EX_rs, EX_rt, EX_dst, EX_RegWrite); end
    vectors++; if (EX_rt_data !== 32'h5A5A_000B || EX_imm !== 32'h0000_010A || EX_PC4 !== 32'h0000_040A) begin miscompares++; $display("FAIL lu_replay_data got=%h/%h/%h exp=5a5a000b/0000010a/0000040a", EX_rt_data, EX_imm, EX_PC4); end
    vectors++; if (StallCount !== 16'(exp_stall)) begin miscompares++; $display("FAIL lu_count_hold got=%0d exp=%0d", StallCount, exp_stall); end
  endtask

  task automatic test_false_dep();
    drive_lw(5'd8, 5'd9);
    step();
    // lui $8: reads nothing
    drive_instr(5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++; if (Stall !== 1'b0) begin miscompares++; $display("FAIL false_lui got=%b exp=0", Stall); end
    step();
    vectors++; if (EX_valid !== 1'b1 || EX_dst !== 5'd8) begin miscompares++; $display("FAIL false_lui_capture got=%b/%0d exp=1/8", EX_valid, EX_dst); end
    drive_lw(5'd0, 5'd9);
    step();
    vectors++; if (EX_dst !== 5'd0 || EX_RegWrite !== 1'b0 || EX_MemRead !== 1'b1) begin miscompares++; $display("FAIL false_lw0 got=%0d/%b/%b exp=0/0/1", EX_dst, EX_RegWrite, EX_MemRead); end
    // add $3, $0, $0
    drive_instr(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++; if (Stall !== 1'b0) begin miscompares++; $display("FAIL false_reg0 got=%b exp=0", Stall); end
    step();
    vectors++; if (StallCount !== 16'(exp_stall)) begin miscompares++; $display("FAIL false_count got=%0d exp=%0d", StallCount, exp_stall); end
  endtask

  task automatic test_zero_squash();
    // addu $0, $1, $2
    drive_instr(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    step();
    vectors++; if (EX_valid !== 1'b1 || EX_dst !== 5'd0 || EX_RegWrite !== 1'b0) begin miscompares++; $display("FAIL zero_addu got=%b/%0d/%b exp=1/0/0", EX_valid, EX_dst, EX_RegWrite); end
    // jal: RegDst = $31
    drive_instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    step();
    vectors++; if (EX_dst !== 5'd31 || EX_RegWrite !== 1'b1 || EX_RegDst !== 2'd2) begin miscompares++; $display("FAIL zero_jal got=%0d/%b/%0d exp=31/1/2", EX_dst, EX_RegWrite, EX_RegDst); end
  endtask

  task automatic test_flush_vs_stall();
    drive_lw(5'd8, 5'd9);
    step();
    // sw $8, 0($4): dependency through rt only
    drive_instr(5'd4, 5'd8, 5'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    #1;
    vectors++; if (Stall !== 1'b1) begin miscompares++; $display("FAIL flush_rt_dep got=%b exp=1", Stall); end
    Flush = 1'b1;
    #1;
    vectors++; if (Stall !== 1'b0) begin miscompares++; $display("FAIL flush_masks_stall got=%b exp=0", Stall); end
    step();
    exp_flush++;
    Flush = 1'b0;
    vectors++; if (EX_valid !== 1'b0 || EX_MemWrite !== 1'b0 || EX_rt !== 5'd0) begin miscompares++; $display("FAIL flush_bubble got=%b/%b/%0d exp=0/0/0", EX_valid, EX_MemWrite, EX_rt); end
    vectors++; if (FlushCount !== 16'(exp_flush) || StallCount !== 16'(exp_stall)) begin miscompares++; $display("FAIL flush_counts got=%0d/%0d exp=%0d/%0d", FlushCount, StallCount, exp_flush, exp_stall); end
    drive_nop();
    step();
  endtask

  task automatic test_back_to_back();
    drive_lw(5'd5, 5'd1);
    step();
    drive_lw(5'd6, 5'd5);
    #1;
    vectors++; if (Stall !== 1'b1) begin miscompares++; $display("FAIL b2b_first_stall got=%b exp=1", Stall); end
    step();
    exp_stall++;
    vectors++; if (Stall !== 1'b0 || EX_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_first_bubble got=%b/%b exp=0/0", Stall, EX_valid); end
    step();
    vectors++; if (EX_dst !== 5'd6 || EX_MemRead !== 1'b1) begin miscompares++; $display("FAIL b2b_second_load got=%0d/%b exp=6/1", EX_dst, EX_MemRead); end
    // add $7, $6, $5
    drive_instr(5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++; if (Stall !== 1'b1) begin miscompares++; $display("FAIL b2b_second_stall got=%b exp=1", Stall); end
    step();
    exp_stall++;
    step();
    vectors++; if (EX_valid !== 1'b1 || EX_dst !== 5'd7 || Stall !== 1'b0) begin miscompares++; $display("FAIL b2b_consumer got=%b/%0d/%b exp=1/7/0", EX_valid, EX_dst, Stall); end
    vectors++; if (StallCount !== 16'(exp_stall)) begin miscompares++; $display("FAIL b2b_count got=%0d exp=%0d", StallCount, exp_stall); end
  endtask

  task automatic test_saturation();
    int to_sat;
    drive_nop();
    to_sat = 65535 - exp_flush;
    Flush = 1'b1;
    for (int i = 0; i < to_sat; i++) begin
      step();
    end
    exp_flush = 65535;
    vectors++; if (FlushCount !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach got=%0d exp=65535", FlushCount); end
    for (int i = 0; i < 5; i++) begin
      step();
    end
    Flush = 1'b0;
    vectors++; if (FlushCount !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got=%0d exp=65535", FlushCount); end
    vectors++; if (StallCount !== 16'(exp_stall)) begin miscompares++; $display("FAIL sat_stall_untouched got=%0d exp=%0d", StallCount, exp_stall); end
    step();
    vectors++; if (EX_valid !== 1'b1 || FlushCount !== 16'hFFFF) begin miscompares++; $display("FAIL sat_resume got=%b/%0d exp=1/65535", EX_valid, FlushCount); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_stall   = 0;
    exp_flush   = 0;
    reset_n     = 1'b0;
    Flush       = 1'b0;
    drive_nop();
    test_reset();
    test_load_use();
    test_false_dep();
    test_zero_squash();
    test_flush_vs_stall();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
